// File: rtl/q_max_sequencer_if.sv
// Handshake/bus bundle between the decision controller, the Q-table read
// port and the policy generator. The slave view is the sequencer itself.
interface q_max_sequencer_if #(
  parameter int L_WIDTH = 4,
  parameter int Q_WIDTH = 16,
  parameter int S_WIDTH = 8
);
  localparam int A_DUR_WIDTH = L_WIDTH / 2;
  localparam int ADDR_WIDTH  = S_WIDTH + 2 + A_DUR_WIDTH;

  logic                          start;
  logic [S_WIDTH-1:0]            state_in;
  logic [1:0]                    road_in;
  logic                          sel_in;
  logic                          q_rd_en;
  logic [ADDR_WIDTH-1:0]         q_rd_addr;
  logic signed [Q_WIDTH-1:0]     q_rd_data;
  logic signed [Q_WIDTH-1:0]     Q_max;
  logic [A_DUR_WIDTH-1:0]        A_dur_best;
  logic [1:0]                    A_road;
  logic                          A_sel;
  logic                          busy;
  logic                          done;

  modport slave (
    input  start, state_in, road_in, sel_in, q_rd_data,
    output q_rd_en, q_rd_addr, Q_max, A_dur_best, A_road, A_sel, busy, done
  );

  modport master (
    output start, state_in, road_in, sel_in, q_rd_data,
    input  q_rd_en, q_rd_addr, Q_max, A_dur_best, A_road, A_sel, busy, done
  );
endinterface

// File: rtl/q_max_sequencer.sv
// Per-decision controller: latches state/road/explore on start, reads the
// N_LEVEL duration Q-values for that state/road one per cycle, tracks the
// signed maximum (lowest index wins ties) and presents the result with a
// one-cycle done strobe. All outputs come straight from registers.
module q_max_sequencer #(
  parameter int L_WIDTH = 4,
  parameter int Q_WIDTH = 16,
  parameter int S_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  q_max_sequencer_if.slave  bus
);
  localparam int A_DUR_WIDTH = L_WIDTH / 2;
  localparam int N_LEVEL     = 1 << A_DUR_WIDTH;
  localparam int ADDR_WIDTH  = S_WIDTH + 2 + A_DUR_WIDTH;
  localparam logic [A_DUR_WIDTH-1:0] CNT_LAST = A_DUR_WIDTH'(N_LEVEL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state, w_next;
  logic [S_WIDTH-1:0]        r_st, w_st;
  logic [1:0]                r_road, w_road;
  logic                      r_sel, w_sel;
  logic [A_DUR_WIDTH-1:0]    r_cnt, w_cnt;

  logic                      r_rd_en;
  logic [ADDR_WIDTH-1:0]     r_rd_addr;
  logic                      r_vld;
  logic [A_DUR_WIDTH-1:0]    r_ret_idx;
  logic signed [Q_WIDTH-1:0] r_run_max, w_run_max;
  logic [A_DUR_WIDTH-1:0]    r_run_idx, w_run_idx;

  logic signed [Q_WIDTH-1:0] r_q_max;
  logic [A_DUR_WIDTH-1:0]    r_a_dur;
  logic [1:0]                r_a_road;
  logic                      r_a_sel;
  logic                      r_busy;
  logic                      r_done;

  // Next state, context latch on accepted start, and read-duration counter.
  always_comb begin
    w_next = r_state;
    w_st   = r_st;
    w_road = r_road;
    w_sel  = r_sel;
    w_cnt  = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_READ;
          w_st   = bus.state_in;
          w_road = bus.road_in;
          w_sel  = bus.sel_in;
          w_cnt  = {A_DUR_WIDTH{1'b0}};
        end else begin
          w_next = S_IDLE;
        end
      end
      S_READ: begin
        // r_cnt is the duration of the read being issued in this cycle
        if (r_cnt == CNT_LAST) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_READ;
          w_cnt  = r_cnt + A_DUR_WIDTH'(1'b1);
        end
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Running signed maximum; duration 0 loads unconditionally, later values only if strictly greater.
  always_comb begin
    w_run_max = r_run_max;
    w_run_idx = r_run_idx;
    if (r_vld) begin
      if ((r_ret_idx == {A_DUR_WIDTH{1'b0}}) || (bus.q_rd_data > r_run_max)) begin
        w_run_max = bus.q_rd_data;
        w_run_idx = r_ret_idx;
      end else begin
        w_run_max = r_run_max;
        w_run_idx = r_run_idx;
      end
    end else begin
      w_run_max = r_run_max;
      w_run_idx = r_run_idx;
    end
  end

  // FSM state register and latched decision context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_st    <= {S_WIDTH{1'b0}};
      r_road  <= 2'b00;
      r_sel   <= 1'b0;
      r_cnt   <= {A_DUR_WIDTH{1'b0}};
    end else begin
      r_state <= w_next;
      r_st    <= w_st;
      r_road  <= w_road;
      r_sel   <= w_sel;
      r_cnt   <= w_cnt;
    end
  end

  // Read port, returning-data tracking, status strobes and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= {ADDR_WIDTH{1'b0}};
      r_vld     <= 1'b0;
      r_ret_idx <= {A_DUR_WIDTH{1'b0}};
      r_run_max <= {Q_WIDTH{1'b0}};
      r_run_idx <= {A_DUR_WIDTH{1'b0}};
      r_q_max   <= {Q_WIDTH{1'b0}};
      r_a_dur   <= {A_DUR_WIDTH{1'b0}};
      r_a_road  <= 2'b00;
      r_a_sel   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en   <= (w_next == S_READ);
      // address is forced to zero whenever no read is issued
      r_rd_addr <= (w_next == S_READ) ? {w_st, w_road, w_cnt} : {ADDR_WIDTH{1'b0}};
      // data for a read issued this cycle arrives next cycle, tagged with its duration
      r_vld     <= r_rd_en;
      r_ret_idx <= r_rd_addr[A_DUR_WIDTH-1:0];
      r_run_max <= w_run_max;
      r_run_idx <= w_run_idx;
      r_busy    <= (w_next == S_READ) || (w_next == S_DRAIN);
      r_done    <= (w_next == S_DONE);
      // results change only on entry to DONE and then hold until the next one
      if (w_next == S_DONE) begin
        r_q_max  <= w_run_max;
        r_a_dur  <= w_run_idx;
        r_a_road <= r_road;
        r_a_sel  <= r_sel;
      end else begin
        r_q_max  <= r_q_max;
        r_a_dur  <= r_a_dur;
        r_a_road <= r_a_road;
        r_a_sel  <= r_a_sel;
      end
    end
  end

  assign bus.q_rd_en    = r_rd_en;
  assign bus.q_rd_addr  = r_rd_addr;
  assign bus.Q_max      = r_q_max;
  assign bus.A_dur_best = r_a_dur;
  assign bus.A_road     = r_a_road;
  assign bus.A_sel      = r_a_sel;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule
